// File: rtl/bt656_pkg.sv
// Shared BT.656 constants and helpers: timing-reference preamble, blanking codes,
// XY protection word and reserved-code clamp. Used by both encoder and decoder.
package bt656_pkg;

    localparam logic [7:0]  PREAMBLE_FF = 8'hFF;
    localparam logic [7:0]  PREAMBLE_00 = 8'h00;
    localparam logic [7:0]  BLANK_C     = 8'h80;
    localparam logic [7:0]  BLANK_Y     = 8'h10;
    localparam logic [15:0] BLACK_PIXEL = {BLANK_Y, BLANK_C};

    // What the current byte slot carries.
    typedef enum logic [1:0] {
        KindBlank,
        KindCode,
        KindPixel
    } byte_kind_e;

    function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    // 00 and FF are reserved for timing references.
    function automatic logic [7:0] clamp_video(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b == 8'h00) r = 8'h01;
        if (b == 8'hFF) r = 8'hFE;
        return r;
    endfunction

endpackage

// File: rtl/bt656_encoder_if.sv
// Pixel-FIFO pull side and BT.656 output side of the encoder.
interface bt656_encoder_if;

    logic [15:0] pix_data;
    logic        pix_empty;
    logic        pix_rd;
    logic [7:0]  bt_data;
    logic        field;
    logic        v_blank;
    logic        h_blank;
    logic        underrun;

    modport master (
        input  pix_data, pix_empty,
        output pix_rd, bt_data, field, v_blank, h_blank, underrun
    );

    modport slave (
        output pix_data, pix_empty,
        input  pix_rd, bt_data, field, v_blank, h_blank, underrun
    );

endinterface

// File: rtl/bt656_timing.sv
// Byte/line raster counters for a 525-line BT.656 frame, plus per-byte classification
// (code/blank/pixel), F/V bits and the pixel fetch strobe.
module bt656_timing
    import bt656_pkg::*;
#(
    parameter int unsigned LINE_BYTES   = 1716,
    parameter int unsigned ACTIVE_BYTES = 1440,
    parameter int unsigned LINES        = 525,
    parameter int unsigned F1_START     = 4,
    parameter int unsigned F2_START     = 266,
    parameter int unsigned VA_END       = 19,
    parameter int unsigned VB_START     = 264,
    parameter int unsigned VB_END       = 282
) (
    input  logic       clk,
    input  logic       reset,
    output byte_kind_e o_kind,
    output logic [1:0] o_code_idx,
    output logic       o_code_h,
    output logic       o_odd,
    output logic       o_f,
    output logic       o_v,
    output logic       o_active,
    output logic       o_fetch
);

    localparam int unsigned BW           = $clog2(LINE_BYTES);
    localparam int unsigned LW           = $clog2(LINES + 1);
    localparam int unsigned ACTIVE_START = LINE_BYTES - ACTIVE_BYTES;
    localparam int unsigned SAV_START    = ACTIVE_START - 4;
    localparam int unsigned FETCH_FIRST  = ACTIVE_START - 1;
    localparam int unsigned FETCH_LAST   = LINE_BYTES - 3;
    localparam logic [1:0]  SAV_PHASE    = 2'(SAV_START % 4);
    localparam logic        FETCH_PAR    = 1'(FETCH_FIRST % 2);
    localparam logic        ACTIVE_PAR   = 1'(ACTIVE_START % 2);

    logic [BW-1:0] r_byte_cnt;
    logic [LW-1:0] r_line_cnt;
    logic          w_eav;
    logic          w_sav;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_cnt <= '0;
            r_line_cnt <= LW'(1);
        end else if (r_byte_cnt == BW'(LINE_BYTES - 1)) begin
            r_byte_cnt <= '0;
            r_line_cnt <= (r_line_cnt == LW'(LINES)) ? LW'(1) : r_line_cnt + 1'b1;
        end else begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
        end
    end

    always_comb begin
        w_eav      = r_byte_cnt < BW'(4);
        w_sav      = (r_byte_cnt >= BW'(SAV_START)) && (r_byte_cnt < BW'(ACTIVE_START));
        o_active   = r_byte_cnt >= BW'(ACTIVE_START);
        o_f        = !((r_line_cnt >= LW'(F1_START)) && (r_line_cnt < LW'(F2_START)));
        o_v        = (r_line_cnt <= LW'(VA_END)) ||
                     ((r_line_cnt >= LW'(VB_START)) && (r_line_cnt <= LW'(VB_END)));
        o_code_h   = w_eav;
        o_code_idx = w_eav ? r_byte_cnt[1:0] : r_byte_cnt[1:0] - SAV_PHASE;
        // One fetch per pixel, one byte ahead of its chroma slot.
        o_fetch    = !o_v && (r_byte_cnt >= BW'(FETCH_FIRST)) &&
                     (r_byte_cnt <= BW'(FETCH_LAST)) && (r_byte_cnt[0] == FETCH_PAR);
        o_kind     = KindBlank;
        o_odd      = r_byte_cnt[0];
        if (w_eav || w_sav) begin
            o_kind = KindCode;
        end else if (o_active && !o_v) begin
            o_kind = KindPixel;
            o_odd  = r_byte_cnt[0] ^ ACTIVE_PAR;
        end
    end

endmodule

// File: rtl/bt656_encoder.sv
// BT.656 525-line byte-stream generator: EAV/SAV codes, blanking fill and Cb-Y-Cr-Y
// active video pulled from a show-ahead pixel FIFO, with sticky underrun flag.
module bt656_encoder
    import bt656_pkg::*;
#(
    parameter int unsigned LINE_BYTES   = 1716,
    parameter int unsigned ACTIVE_BYTES = 1440,
    parameter int unsigned LINES        = 525,
    parameter int unsigned F1_START     = 4,
    parameter int unsigned F2_START     = 266,
    parameter int unsigned VA_END       = 19,
    parameter int unsigned VB_START     = 264,
    parameter int unsigned VB_END       = 282
) (
    input logic             clk,
    input logic             reset,
    bt656_encoder_if.master io_vid
);

    byte_kind_e  w_kind;
    logic [1:0]  w_code_idx;
    logic        w_code_h;
    logic        w_odd;
    logic        w_f;
    logic        w_v;
    logic        w_active;
    logic        w_fetch;
    logic [7:0]  w_byte;

    logic [15:0] r_pix;
    logic [7:0]  r_bt_data;
    logic        r_field;
    logic        r_v_blank;
    logic        r_h_blank;
    logic        r_underrun;

    bt656_timing #(
        .LINE_BYTES  (LINE_BYTES),
        .ACTIVE_BYTES(ACTIVE_BYTES),
        .LINES       (LINES),
        .F1_START    (F1_START),
        .F2_START    (F2_START),
        .VA_END      (VA_END),
        .VB_START    (VB_START),
        .VB_END      (VB_END)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .o_kind    (w_kind),
        .o_code_idx(w_code_idx),
        .o_code_h  (w_code_h),
        .o_odd     (w_odd),
        .o_f       (w_f),
        .o_v       (w_v),
        .o_active  (w_active),
        .o_fetch   (w_fetch)
    );

    always_comb begin
        w_byte = BLANK_Y;
        unique case (w_kind)
            KindCode: begin
                case (w_code_idx)
                    2'd0:    w_byte = PREAMBLE_FF;
                    2'd3:    w_byte = xy_code(w_f, w_v, w_code_h);
                    default: w_byte = PREAMBLE_00;
                endcase
            end
            KindPixel: w_byte = clamp_video(w_odd ? r_pix[15:8] : r_pix[7:0]);
            default:   w_byte = w_odd ? BLANK_Y : BLANK_C;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix      <= BLACK_PIXEL;
            r_bt_data  <= BLANK_Y;
            r_field    <= 1'b1;
            r_v_blank  <= 1'b1;
            r_h_blank  <= 1'b1;
            r_underrun <= 1'b0;
        end else begin
            r_bt_data <= w_byte;
            r_field   <= w_f;
            r_v_blank <= w_v;
            r_h_blank <= !w_active;
            // An empty FIFO yields a black pixel; the raster never waits.
            if (w_fetch) begin
                r_pix <= io_vid.pix_empty ? BLACK_PIXEL : io_vid.pix_data;
                if (io_vid.pix_empty) r_underrun <= 1'b1;
            end
        end
    end

    assign io_vid.pix_rd   = w_fetch && !io_vid.pix_empty && !reset;
    assign io_vid.bt_data  = r_bt_data;
    assign io_vid.field    = r_field;
    assign io_vid.v_blank  = r_v_blank;
    assign io_vid.h_blank  = r_h_blank;
    assign io_vid.underrun = r_underrun;

endmodule

// File: tb/tb_bt656_encoder.sv
// Directed bench for bt656_encoder on a shortened line (32 bytes, 8 pixels) with the
// standard 525-line vertical timing, so whole frames stay short.
module tb_bt656_encoder;

    localparam int LB             = 32;
    localparam int AB             = 16;
    localparam int NL             = 525;
    localparam int FRAME          = LB * NL;
    localparam int POPS_PER_FRAME = 487 * (AB / 2);
    localparam int FIRST_RD_IDX   = 19 * LB + (LB - AB - 1);

    typedef struct {
        int         line;
        int         bidx;
        logic [7:0] data;
        logic       f;
        logic       v;
        logic       h;
        logic       u;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bt656_encoder_if vid ();

    bt656_encoder #(
        .LINE_BYTES  (LB),
        .ACTIVE_BYTES(AB)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .io_vid(vid)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          pops = 0;
    int          first_rd = -1;
    bit          always_full = 1'b0;
    logic [15:0] gen = 16'h4020;
    logic [15:0] fifo [$];
    vec_t        tab1 [$];
    vec_t        tab2 [$];

    function automatic vec_t mk(input int l, input int b, input logic [7:0] d,
                                input logic f, input logic v, input logic h, input logic u);
        vec_t r;
        r.line = l; r.bidx = b; r.data = d; r.f = f; r.v = v; r.h = h; r.u = u;
        return r;
    endfunction

    task automatic drive_src();
        if (always_full) begin
            vid.pix_empty = 1'b0;
            vid.pix_data  = gen;
        end else if (fifo.size() == 0) begin
            vid.pix_empty = 1'b1;
            vid.pix_data  = 16'hDEAD;
        end else begin
            vid.pix_empty = 1'b0;
            vid.pix_data  = fifo[0];
        end
    endtask

    // One clock; pops the source model when the DUT strobed pix_rd into this edge.
    task automatic tick();
        logic rd;
        @(negedge clk);
        rd = vid.pix_rd;
        if (rd && first_rd < 0) first_rd = cyc % FRAME;
        @(posedge clk);
        #1;
        if (rd) begin
            pops++;
            if (always_full) gen = gen + 16'h0101;
            else if (fifo.size() != 0) void'(fifo.pop_front());
        end
        cyc++;
        drive_src();
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] d, input logic f,
                             input logic v, input logic h, input logic u);
        n_vec++;
        if ({vid.bt_data, vid.field, vid.v_blank, vid.h_blank, vid.underrun} !== {d, f, v, h, u})
        begin
            n_err++;
            $display("FAIL %s: got data=%h F%b V%b H%b U%b, want data=%h F%b V%b H%b U%b",
                     name, vid.bt_data, vid.field, vid.v_blank, vid.h_blank, vid.underrun,
                     d, f, v, h, u);
        end
    endtask

    // Advance until the outputs show byte (line, bidx); output after tick n is index n-1.
    task automatic run_to(input int line, input int bidx);
        int target;
        int n;
        target = (line - 1) * LB + bidx;
        n = 0;
        while ((cyc + FRAME - 1) % FRAME != target) begin
            if (n > FRAME) begin
                n_vec++;
                n_err++;
                $display("FAIL run_to L%0d B%0d: position not reached", line, bidx);
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic apply(input vec_t v);
        run_to(v.line, v.bidx);
        check_out($sformatf("L%0d B%0d", v.line, v.bidx), v.data, v.f, v.v, v.h, v.u);
    endtask

    initial begin
        // Line 1, FIFO empty.
        tab1.push_back(mk(1,  0, 8'hFF, 1, 1, 1, 0));
        tab1.push_back(mk(1,  1, 8'h00, 1, 1, 1, 0));
        tab1.push_back(mk(1,  2, 8'h00, 1, 1, 1, 0));
        tab1.push_back(mk(1,  3, 8'hF1, 1, 1, 1, 0));
        tab1.push_back(mk(1,  4, 8'h80, 1, 1, 1, 0));
        tab1.push_back(mk(1,  5, 8'h10, 1, 1, 1, 0));
        tab1.push_back(mk(1, 11, 8'h10, 1, 1, 1, 0));
        tab1.push_back(mk(1, 12, 8'hFF, 1, 1, 1, 0));
        tab1.push_back(mk(1, 13, 8'h00, 1, 1, 1, 0));
        tab1.push_back(mk(1, 14, 8'h00, 1, 1, 1, 0));
        tab1.push_back(mk(1, 15, 8'hEC, 1, 1, 1, 0));
        tab1.push_back(mk(1, 16, 8'h80, 1, 1, 0, 0));
        tab1.push_back(mk(1, 17, 8'h10, 1, 1, 0, 0));
        tab1.push_back(mk(1, 31, 8'h10, 1, 1, 0, 0));
        // Line 20 with eight queued words, then empty FIFO, vertical edges and frame wrap.
        tab2.push_back(mk(20,  3, 8'h9D, 0, 0, 1, 0));
        tab2.push_back(mk(20,  4, 8'h80, 0, 0, 1, 0));
        tab2.push_back(mk(20, 15, 8'h80, 0, 0, 1, 0));
        tab2.push_back(mk(20, 16, 8'h55, 0, 0, 0, 0));
        tab2.push_back(mk(20, 17, 8'h2A, 0, 0, 0, 0));
        tab2.push_back(mk(20, 18, 8'hAA, 0, 0, 0, 0));
        tab2.push_back(mk(20, 19, 8'h3B, 0, 0, 0, 0));
        tab2.push_back(mk(20, 20, 8'h01, 0, 0, 0, 0));
        tab2.push_back(mk(20, 21, 8'hFE, 0, 0, 0, 0));
        tab2.push_back(mk(20, 22, 8'hFE, 0, 0, 0, 0));
        tab2.push_back(mk(20, 23, 8'h01, 0, 0, 0, 0));
        tab2.push_back(mk(20, 24, 8'h34, 0, 0, 0, 0));
        tab2.push_back(mk(20, 25, 8'h12, 0, 0, 0, 0));
        tab2.push_back(mk(20, 26, 8'h78, 0, 0, 0, 0));
        tab2.push_back(mk(20, 27, 8'h56, 0, 0, 0, 0));
        tab2.push_back(mk(20, 28, 8'hBC, 0, 0, 0, 0));
        tab2.push_back(mk(20, 29, 8'h9A, 0, 0, 0, 0));
        tab2.push_back(mk(20, 30, 8'hF0, 0, 0, 0, 0));
        tab2.push_back(mk(20, 31, 8'hDE, 0, 0, 0, 0));
        tab2.push_back(mk(21, 15, 8'h80, 0, 0, 1, 1));
        tab2.push_back(mk(21, 16, 8'h80, 0, 0, 0, 1));
        tab2.push_back(mk(21, 17, 8'h10, 0, 0, 0, 1));
        tab2.push_back(mk(21, 18, 8'h80, 0, 0, 0, 1));
        tab2.push_back(mk(21, 19, 8'h10, 0, 0, 0, 1));
        tab2.push_back(mk(263, 15, 8'h80, 0, 0, 1, 1));
        tab2.push_back(mk(264, 15, 8'hAB, 0, 1, 1, 1));
        tab2.push_back(mk(264, 16, 8'h80, 0, 1, 0, 1));
        tab2.push_back(mk(265,  3, 8'hB6, 0, 1, 1, 1));
        tab2.push_back(mk(266,  3, 8'hF1, 1, 1, 1, 1));
        tab2.push_back(mk(270, 15, 8'hEC, 1, 1, 1, 1));
        tab2.push_back(mk(282, 15, 8'hEC, 1, 1, 1, 1));
        tab2.push_back(mk(283,  3, 8'hDA, 1, 0, 1, 1));
        tab2.push_back(mk(283, 15, 8'hC7, 1, 0, 1, 1));
        tab2.push_back(mk(283, 20, 8'h80, 1, 0, 0, 1));
        tab2.push_back(mk(283, 21, 8'h10, 1, 0, 0, 1));
        tab2.push_back(mk(525,  3, 8'hDA, 1, 0, 1, 1));
        tab2.push_back(mk(1,    3, 8'hF1, 1, 1, 1, 1));
        tab2.push_back(mk(3,   15, 8'hEC, 1, 1, 1, 1));
        tab2.push_back(mk(4,    3, 8'hB6, 0, 1, 1, 1));

        drive_src();
        repeat (3) @(posedge clk);
        #1;
        check_out("reset state", 8'h10, 1, 1, 1, 0);
        check_int("reset pix_rd", int'(vid.pix_rd), 0);
        reset = 1'b0;
        cyc = 0;

        for (int i = 0; i < tab1.size(); i++) apply(tab1[i]);

        fifo = '{16'h2A55, 16'h3BAA, 16'hFF00, 16'h00FF,
                 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        drive_src();
        run_to(19, 31);
        check_int("pops on V=1 lines", pops, 0);

        for (int i = 0; i < tab2.size(); i++) apply(tab2[i]);
        check_int("pops line 20", pops, 8);
        check_int("first pix_rd index", first_rd, FIRST_RD_IDX);

        // Reset lands on a fetch byte of line 100; it must neither pop nor leave state.
        always_full = 1'b1;
        drive_src();
        run_to(100, 20);
        pops = 0;
        first_rd = -1;
        reset = 1'b1;
        tick();
        check_out("mid-line reset", 8'h10, 1, 1, 1, 0);
        reset = 1'b0;
        cyc = 0;
        tick();
        check_out("restart L1 B0", 8'hFF, 1, 1, 1, 0);
        repeat (FRAME - 1) tick();
        check_int("pops full frame", pops, POPS_PER_FRAME);
        check_int("underrun full FIFO", int'(vid.underrun), 0);
        check_int("first pix_rd after reset", first_rd, FIRST_RD_IDX);
        tick();
        check_out("wrap to L1 B0", 8'hFF, 1, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
